// File: rtl/button_pkg.sv
// Shared types, channel indices and timing helper for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_LONG     = 2'd2
  } btn_state_t;

  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button pins in, conditioned levels and event pulses out.
interface button_conditioner_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] pressed;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_pulse;

  modport master (
    output btn_n,
    input  pressed, press_pulse, release_pulse, long_pulse
  );

  modport slave (
    input  btn_n,
    output pressed, press_pulse, release_pulse, long_pulse
  );
endinterface

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, debounce counter and press/long FSM.
//   state       | meaning
//   ST_RELEASED | button up, hold counter cleared
//   ST_PRESSED  | press accepted, hold counter running
//   ST_LONG     | long-press pulse issued, waiting for release
module debounce_channel
  import button_pkg::*;
#(
  parameter int DB_CYC   = 4,
  parameter int LONG_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DB_W   = $clog2(DB_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  logic              sync_q1;
  logic              sync_q2;
  logic              s;
  logic              differ;
  logic              db_done;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  btn_state_t        state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
    end
  end

  // pressed doubles as the accepted debounced level
  assign s       = ~sync_q2;
  assign differ  = s ^ pressed;
  assign db_done = differ && (db_cnt == DB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
    end else if (!differ || db_done) begin
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RELEASED;
      hold_cnt      <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (state)
        ST_RELEASED: begin
          hold_cnt <= '0;
          if (db_done) begin
            state       <= ST_PRESSED;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
          end
        end
        ST_PRESSED: begin
          // an accepted release beats a long-press threshold on the same edge
          if (db_done) begin
            state         <= ST_RELEASED;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= ST_LONG;
            long_pulse <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (db_done) begin
            state         <= ST_RELEASED;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
          end
        end
        default: begin
          state    <= ST_RELEASED;
          pressed  <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the active-low board buttons into clean levels and press/release/long pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_BTN       = 2,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input logic           clk,
  input logic           rst,
  button_conditioner_if.slave bus
);

  localparam int DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);

  if (DB_CYC < 1 || LONG_CYC <= DB_CYC) begin : g_bad_timing
    $error("button_conditioner: need DB_CYC >= 1 and LONG_CYC > DB_CYC");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_channel #(
      .DB_CYC   (DB_CYC),
      .LONG_CYC (LONG_CYC)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .btn_n         (bus.btn_n[i]),
      .pressed       (bus.pressed[i]),
      .press_pulse   (bus.press_pulse[i]),
      .release_pulse (bus.release_pulse[i]),
      .long_pulse    (bus.long_pulse[i])
    );
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner for the board's active-low push buttons (S5 start, S6 stop), feeding the countdown/alarm timer. Synchronises each raw pin to `clk`, debounces it, and produces a clean level plus single-cycle press, release and long-press pulses. The timer consumes these pulses instead of sampling raw pin levels.

## Interface
- `CLK_HZ`, 50_000_000: reference clock frequency.
- `N_BTN`, 2: number of button channels; bit 0 = S5, bit 1 = S6.
- `DEBOUNCE_MS`, 20: stable time required before a level change is accepted.
- `LONG_MS`, 1000: hold time, measured from accepted press, for `long_pulse`.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_n`  in  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to `clk`.
- `pressed`  out  N_BTN  debounced level, active-high.
- `press_pulse`  out  N_BTN  one-cycle pulse on accepted press.
- `release_pulse`  out  N_BTN  one-cycle pulse on accepted release.
- `long_pulse`  out  N_BTN  one-cycle pulse, once per press, when held `LONG_MS`.

## Operation
- Derived constants: DB_CYC = CLK_HZ/1000*DEBOUNCE_MS; LONG_CYC = CLK_HZ/1000*LONG_MS. Elaboration error unless DB_CYC ≥ 1 and LONG_CYC > DB_CYC.
- Per channel, independent; channels share no state.
- Synchroniser: two flops, reset to 1 (released); output inverted to active-high `s`.
- Debounce counter, width clog2(DB_CYC+1): cleared whenever `s` == current accepted level; increments while they differ. When it reaches DB_CYC-1 and they still differ, accepted level toggles next edge and counter clears. Any glitch back to the accepted level clears the counter (no partial credit).
- FSM per channel, states RELEASED, PRESSED, LONG:
  - RELEASED → PRESSED on accepted press; `press_pulse` high for that cycle.
  - PRESSED → LONG when hold counter reaches LONG_CYC-1; `long_pulse` high one cycle.
  - PRESSED or LONG → RELEASED on accepted release; `release_pulse` high one cycle.
  - LONG holds until release; no repeat pulses.
- Hold counter, width clog2(LONG_CYC+1): cleared in RELEASED; increments in PRESSED; frozen in LONG. Counts from the cycle after the accepted press, so the long threshold is measured from acceptance, not raw edge.
- `pressed` = 1 in PRESSED and LONG.
- Reset (any time, including mid-press or mid-debounce): all counters 0, FSM RELEASED, sync flops 1, all outputs 0. A button held through reset deassertion is treated as a fresh press: `press_pulse` after normal debounce.

## Timing
- All outputs registered; none combinational from `btn_n`.
- Press latency: `btn_n` falls and stays low → `press_pulse` high on rising edge 2 + DB_CYC after the first sampling edge; `pressed` rises the same edge.
- Release latency: symmetric, 2 + DB_CYC edges.
- `long_pulse`: LONG_CYC edges after the `press_pulse` edge.
- Pulses last exactly one cycle. `press_pulse` and `release_pulse` never coincide on one channel. Minimum spacing between them is DB_CYC cycles.
- If a release is accepted on the same edge the hold counter would fire, release wins: no `long_pulse`, FSM → RELEASED.
- Both channels pressed simultaneously: pulses may coincide across bits; no arbitration here (the consumer prioritises S5 over S6).

## Structure
- Package `button_pkg`: FSM state enum (RELEASED, PRESSED, LONG), function `ms_to_cycles(clk_hz, ms)`, channel index constants `BTN_START=0`, `BTN_STOP=1`.
- Sub-module `debounce_channel`: one synchroniser, debounce counter and FSM. Instantiated N_BTN times by a generate loop in `button_conditioner`. The top level contains only the generate loop and the port bit-slicing.

## Test plan
Bench parameters: CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20 (DB_CYC=4, LONG_CYC=20).
- Clean press: `btn_n[0]` 1→0 and held → `press_pulse[0]` one cycle at edge 6, `pressed[0]`=1 from edge 6. Bit 1 outputs stay 0.
- Bounce: `btn_n[0]` low 3 cycles, high 1, low steady → no pulse until 4 consecutive low synced samples, then exactly one `press_pulse`.
- Long press: hold `btn_n[1]` low 40 cycles → `press_pulse[1]`, then `long_pulse[1]` exactly 20 edges later, once. Release → one `release_pulse[1]` 6 edges after the rising pin.
- Short press: low 10 cycles → `press_pulse` and `release_pulse` only, `long_pulse` never asserted.
- Reset mid-hold: assert `rst` during LONG, all outputs 0 asynchronously. Deassert with pin still low → fresh `press_pulse` 6 edges later, `long_pulse` 20 after that.
- Both buttons pressed on the same cycle → `press_pulse`=2'b11 on a single edge, independent `long_pulse` timing per bit.
